// File: rtl/pc_ctrl_pkg.sv
// Shared types and opcode constants for the branch/PC control sequencer.
package pc_ctrl_pkg;

  localparam int OP_W = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_BRA  = 4'hC;
  localparam opcode_t OP_BZ   = 4'hD;
  localparam opcode_t OP_BNZ  = 4'hE;
  localparam opcode_t OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    UPDATE_INC = 3'd4,
    UPDATE_BR  = 3'd5,
    HALTED     = 3'd6
  } state_t;

  function automatic logic is_branch_op(input opcode_t op);
    return (op == OP_BRA) || (op == OP_BZ) || (op == OP_BNZ);
  endfunction

endpackage

// File: rtl/branch_decode.sv
// Combinational opcode classifier: branch / taken / halt.
module branch_decode
  import pc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            zero_flag,
  output logic            is_branch,
  output logic            taken,
  output logic            is_halt
);

  always_comb begin
    is_branch = is_branch_op(opcode);
    is_halt   = (opcode == OP_HALT);
    taken     = 1'b0;
    unique case (opcode)
      OP_BRA:  taken = 1'b1;
      OP_BZ:   taken = zero_flag;
      OP_BNZ:  taken = ~zero_flag;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Fetch/decode/execute sequencer issuing one PC update pulse per instruction.
module branch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int p_size   = 6,
  parameter int p_iwidth = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [p_iwidth-1:0] instr,
  input  logic                instr_valid,
  input  logic                zero_flag,
  input  logic                ex_done,
  output logic                fetch_req,
  output logic                ex_start,
  output logic                pc_incr,
  output logic                pc_relbranch,
  output logic [p_size-1:0]   branch_addr,
  output logic                halted
);

  state_t              state_q, state_d;
  logic [p_iwidth-1:0] ir_q, ir_d;
  logic                ex_first_q, ex_first_d;

  logic [OP_W-1:0] opcode;
  logic            is_branch, taken, is_halt;

  assign opcode = ir_q[p_iwidth-1 -: OP_W];

  // Middle instruction bits belong to the datapath, not to this block.
  logic ir_unused;
  assign ir_unused = ^ir_q;

  branch_decode u_decode (
    .opcode    (opcode),
    .zero_flag (zero_flag),
    .is_branch (is_branch),
    .taken     (taken),
    .is_halt   (is_halt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      ex_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ex_first_q <= ex_first_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ex_first_d   = 1'b0;
    fetch_req    = 1'b0;
    ex_start     = 1'b0;
    pc_incr      = 1'b0;
    pc_relbranch = 1'b0;
    branch_addr  = '0;
    halted       = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_halt) begin
          state_d = HALTED;
        end else if (is_branch) begin
          state_d = taken ? UPDATE_BR : UPDATE_INC;
        end else begin
          state_d    = EXEC;
          ex_first_d = 1'b1;
        end
      end
      EXEC: begin
        // ex_first_q marks the first EXEC cycle so ex_start is a single pulse.
        ex_start = ex_first_q;
        if (ex_done) state_d = UPDATE_INC;
      end
      UPDATE_BR: begin
        pc_relbranch = 1'b1;
        branch_addr  = ir_q[p_size-1:0];
        state_d      = run ? FETCH : IDLE;
      end
      UPDATE_INC: begin
        pc_incr = 1'b1;
        state_d = run ? FETCH : IDLE;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl.
module tb_branch_ctrl;

  localparam int P_SIZE = 6;
  localparam int P_IW   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic [P_IW-1:0]   instr;
  logic              instr_valid;
  logic              zero_flag;
  logic              ex_done;
  logic              fetch_req;
  logic              ex_start;
  logic              pc_incr;
  logic              pc_relbranch;
  logic [P_SIZE-1:0] branch_addr;
  logic              halted;

  int checks   = 0;
  int failures = 0;

  branch_ctrl #(.p_size(P_SIZE), .p_iwidth(P_IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .zero_flag    (zero_flag),
    .ex_done      (ex_done),
    .fetch_req    (fetch_req),
    .ex_start     (ex_start),
    .pc_incr      (pc_incr),
    .pc_relbranch (pc_relbranch),
    .branch_addr  (branch_addr),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output vector: {fetch_req, ex_start, pc_incr, pc_relbranch, halted, branch_addr}
  task automatic chk(input string tag, input logic f, input logic s, input logic i,
                     input logic r, input logic h, input logic [P_SIZE-1:0] a);
    logic [P_SIZE+4:0] obs, exp_v;
    obs   = {fetch_req, ex_start, pc_incr, pc_relbranch, halted, branch_addr};
    exp_v = {f, s, i, r, h, a};
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
    $display("step %s fetch=%0b start=%0b incr=%0b rel=%0b halt=%0b addr=%0d",
             tag, fetch_req, ex_start, pc_incr, pc_relbranch, halted, branch_addr);
  endtask

  // Starting in FETCH: present a branch word and follow it through to the update.
  task automatic do_branch(input string tag, input logic [P_IW-1:0] word, input logic zf,
                           input logic exp_taken, input logic [P_SIZE-1:0] exp_addr);
    instr = word; instr_valid = 1'b1; zero_flag = zf;
    tick();
    instr_valid = 1'b0;
    chk({tag, "_decode"}, 0, 0, 0, 0, 0, '0);
    tick();
    if (exp_taken) chk({tag, "_update"}, 0, 0, 0, 1, 0, exp_addr);
    else           chk({tag, "_update"}, 0, 0, 1, 0, 0, '0);
    tick();
    chk({tag, "_refetch"}, 1, 0, 0, 0, 0, '0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; instr = '0; instr_valid = 1'b0;
    zero_flag = 1'b0; ex_done = 1'b0;
    tick();
    tick();
    chk("reset_state", 0, 0, 0, 0, 0, '0);

    reset = 1'b0; run = 1'b1;
    tick();
    chk("fetch_after_run", 1, 0, 0, 0, 0, '0);

    // Ordinary opcode 1, ex_done at N+4
    instr = 16'h1005; instr_valid = 1'b1;
    tick();                                   // N+1
    instr_valid = 1'b0;
    chk("ord_decode", 0, 0, 0, 0, 0, '0);
    tick();                                   // N+2
    chk("ord_ex_start", 0, 1, 0, 0, 0, '0);
    tick();                                   // N+3
    chk("ord_exec_wait", 0, 0, 0, 0, 0, '0);
    tick();                                   // N+4
    ex_done = 1'b1;
    chk("ord_exec_done", 0, 0, 0, 0, 0, '0);
    tick();                                   // N+5
    ex_done = 1'b0;
    chk("ord_pc_incr", 0, 0, 1, 0, 0, '0);
    tick();
    chk("ord_refetch", 1, 0, 0, 0, 0, '0);

    do_branch("bra_p20", 16'hC014, 1'b0, 1'b1, 6'd20);
    do_branch("bra_m10", 16'hC036, 1'b1, 1'b1, 6'b110110);
    do_branch("bra_zero_off", 16'hC000, 1'b0, 1'b1, 6'd0);
    do_branch("bz_z1", 16'hD005, 1'b1, 1'b1, 6'd5);
    do_branch("bz_z0", 16'hD005, 1'b0, 1'b0, 6'd0);
    do_branch("bnz_z0", 16'hE005, 1'b0, 1'b1, 6'd5);
    do_branch("bnz_z1", 16'hE005, 1'b1, 1'b0, 6'd0);

    // run dropped at UPDATE returns to IDLE
    instr = 16'hC003; instr_valid = 1'b1; zero_flag = 1'b0;
    tick();
    instr_valid = 1'b0;
    tick();
    run = 1'b0;
    chk("runoff_update", 0, 0, 0, 1, 0, 6'd3);
    tick();
    chk("runoff_idle", 0, 0, 0, 0, 0, '0);
    tick();
    chk("runoff_idle2", 0, 0, 0, 0, 0, '0);
    run = 1'b1;
    tick();
    chk("runon_fetch", 1, 0, 0, 0, 0, '0);

    // reset during EXEC before ex_done
    instr = 16'h2000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("rst_exec_start", 0, 1, 0, 0, 0, '0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_exec_idle", 0, 0, 0, 0, 0, '0);
    tick();
    chk("rst_exec_refetch", 1, 0, 0, 0, 0, '0);

    // reset during FETCH with a valid branch offered
    instr = 16'hC009; instr_valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_fetch_idle", 0, 0, 0, 0, 0, '0);
    tick();
    instr_valid = 1'b0;
    chk("rst_fetch_refetch", 1, 0, 0, 0, 0, '0);

    // HALT holds for 100 cycles despite run/instr_valid/ex_done
    instr = 16'hF000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("halt_decode", 0, 0, 0, 0, 0, '0);
    for (int k = 0; k < 100; k++) begin
      tick();
      instr_valid = k[0];
      ex_done     = k[1];
      chk($sformatf("halted_%0d", k), 0, 0, 0, 0, 1, '0);
    end
    instr_valid = 1'b0; ex_done = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_reset", 0, 0, 0, 0, 0, '0);
    tick();
    chk("halt_reset_fetch", 1, 0, 0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Control sequencer that drives the program counter's control interface (pc_incr, pc_relbranch, branch_addr).
- Fetches an instruction via a request/valid handshake with program memory.
- Decodes branch and halt opcodes; hands other instructions to the datapath with a start/done handshake.
- Issues exactly one single-cycle PC update per instruction.
- Sits between program memory, the datapath and the pc block in the embedded processor.

Parameters:
p_size, 6, PC width; also the width of branch_addr and of the signed offset field.
p_iwidth, 16, instruction word width; must be at least p_size+4.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 allows fetching of the next instruction
instr  input  p_iwidth  instruction word from program memory
instr_valid  input  1  instr is valid this cycle
zero_flag  input  1  datapath zero flag, sampled in DECODE
ex_done  input  1  datapath has finished the current instruction
fetch_req  output  1  request the instruction at the current pc_out
ex_start  output  1  one-cycle pulse: datapath executes the latched instruction
pc_incr  output  1  one-cycle pulse: PC += 1
pc_relbranch  output  1  one-cycle pulse: PC += signed branch_addr
branch_addr  output  p_size  signed offset; valid while pc_relbranch=1, 0 otherwise
halted  output  1  high while in HALTED

Behaviour:
- Interface decisions: one clock; reset is synchronous and active-high. Clock port is clk; reset port is reset.
- Reset: state=IDLE, instruction register=0, all outputs 0.
- Reset mid-operation: abort at the next edge, with no PC pulse emitted. This applies in every state, including HALTED.
- All outputs are Moore, decoded from registered state and the instruction register only; no combinational input-to-output paths.
- Instruction fields: opcode=instr[p_iwidth-1:p_iwidth-4]; offset=instr[p_size-1:0], two's complement.
- Opcodes: 4'hC BRA (always branch), 4'hD BZ (branch if zero_flag=1), 4'hE BNZ (branch if zero_flag=0), 4'hF HALT. Every other opcode is ordinary.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: fetch_req=1. On instr_valid=1, latch instr and go to DECODE. Otherwise stay; there is no timeout.
- DECODE (1 cycle): sample zero_flag.
  - Taken branch -> UPDATE_BR.
  - Not-taken branch -> UPDATE_INC.
  - HALT -> HALTED.
  - Ordinary -> EXEC.
- EXEC: ex_start=1 in the first EXEC cycle only. ex_done is honoured from that same cycle onward. On ex_done=1 go to UPDATE_INC.
- UPDATE_BR: pc_relbranch=1 and branch_addr=offset for exactly 1 cycle.
- UPDATE_INC: pc_incr=1 for exactly 1 cycle.
- After either UPDATE state: go to FETCH if run=1, else IDLE.
- HALTED: halted=1; leave only on reset.
- pc_incr and pc_relbranch are never high together. At most one PC pulse per fetched instruction.
- Offset 0 is legal (self-loop). Negative offsets and PC wrap are the pc block's concern; they pass through unmodified.
- instr_valid outside FETCH is ignored. ex_done outside EXEC is ignored.
- run is sampled only in IDLE and in the UPDATE states. Dropping run mid-instruction completes the current instruction.
- Branch latency: instr_valid at cycle N -> DECODE at N+1 -> pc_relbranch at N+2 -> fetch_req at N+3 (if run=1).
- Ordinary instruction with immediate ex_done: ex_start at N+2, pc_incr at N+3.

Decomposition:
- Package pc_ctrl_pkg: state enum (IDLE, FETCH, DECODE, EXEC, UPDATE_INC, UPDATE_BR, HALTED); opcode constants OP_BRA, OP_BZ, OP_BNZ, OP_HALT; opcode field width 4.
- One natural sub-module: branch_decode, combinational. Inputs are the opcode and zero_flag; outputs are is_branch, taken, is_halt.

Test Plan:
- Reset, then run=1 -> fetch_req=1 on the cycle after run is sampled; all other outputs 0.
- Ordinary opcode 4'h1, instr_valid at N, ex_done at N+4 -> ex_start pulse at N+2 only; pc_incr pulse at N+5; no pc_relbranch.
- BRA with offset 20 (6'd20), p_size=6 -> pc_relbranch=1 and branch_addr=20 at N+2 for exactly 1 cycle. Repeat with offset -10 -> branch_addr=6'b110110.
- BZ offset 5: zero_flag=1 -> pc_relbranch with branch_addr=5. zero_flag=0 -> pc_incr, branch_addr=0. BNZ gives the mirror result.
- HALT -> halted=1 and no PC pulse for 100 cycles with run=1. Then reset=1 -> IDLE, halted=0.
- reset asserted during EXEC (before ex_done) and during FETCH -> IDLE next edge, no pulses. run=0 at UPDATE -> return to IDLE, fetch_req stays 0.
